// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready load/store requests against an internal word array,
// with configurable wait states and a single-cycle response strobe.
module data_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   // state | meaning
   // IDLE  | ready for a request
   // BUSY  | request held, counting wait states
   // RESP  | response strobe driven for one cycle
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic accept, commit;

   logic             we_q;
   logic [1:0]       lane_q;
   logic [IDX_W-1:0] widx_q;
   logic [2:0]       f3_q;
   logic [31:0]      wdata_q;
   logic             err_q;

   logic             in_err;
   logic             cur_we, cur_err;
   logic [1:0]       cur_lane;
   logic [IDX_W-1:0] cur_widx;
   logic [2:0]       cur_f3;
   logic [31:0]      cur_wdata;

   logic [3:0]  byte_en;
   logic [31:0] wr_word, rd_word, rd_shift, load_val;

   logic [31:0] mem [DEPTH];

   always_comb begin
      in_err = 1'b0;
      if (req_we) in_err = (req_funct3 > 3'b010);
      else        in_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      if (req_funct3[1:0] == 2'b01 && req_addr[0])         in_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) in_err = 1'b1;
      if ({{(32-(ADDR_W-2)){1'b0}}, req_addr[ADDR_W-1:2]} >= 32'(DEPTH)) in_err = 1'b1;
   end

   // With zero wait states the commit happens on the accept edge, so use the live request.
   always_comb begin
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_lane  = req_addr[1:0];
         cur_widx  = req_addr[IDX_W+1:2];
         cur_f3    = req_funct3;
         cur_wdata = req_wdata;
         cur_err   = in_err;
      end else begin
         cur_we    = we_q;
         cur_lane  = lane_q;
         cur_widx  = widx_q;
         cur_f3    = f3_q;
         cur_wdata = wdata_q;
         cur_err   = err_q;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = 4'(WAIT_STATES);
               end
            end
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         lane_q  <= 2'd0;
         widx_q  <= '0;
         f3_q    <= 3'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (accept) begin
         we_q    <= req_we;
         lane_q  <= req_addr[1:0];
         widx_q  <= req_addr[IDX_W+1:2];
         f3_q    <= req_funct3;
         wdata_q <= req_wdata;
         err_q   <= in_err;
      end
   end

   always_comb begin
      byte_en = 4'b0000;
      wr_word = cur_wdata;
      case (cur_f3[1:0])
         2'b00: begin
            byte_en = 4'b0001 << cur_lane;
            wr_word = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            byte_en = 4'b0011 << {cur_lane[1], 1'b0};
            wr_word = {2{cur_wdata[15:0]}};
         end
         default: byte_en = 4'b1111;
      endcase
   end

   // Array is deliberately not reset; rst also blocks a commit that would race the reset.
   always_ff @(posedge clk) begin
      if (commit && cur_we && !cur_err && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[cur_widx][8*b +: 8] <= wr_word[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_word  = mem[cur_widx];
      rd_shift = rd_word >> {cur_lane, 3'b000};
      case (cur_f3)
         3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'd0, rd_shift[7:0]};
         3'b101:  load_val = {16'd0, rd_shift[15:0]};
         default: load_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_rdata <= (cur_err || cur_we) ? 32'd0 : load_val;
         rsp_err   <= cur_err;
      end else if (state == RESP) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 (DEPTH=63, 2 wait states), instance 1 (DEPTH=64, 0 wait states),
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv   [2];
   logic        we   [2];
   logic [7:0]  ad   [2];
   logic [2:0]  f3   [2];
   logic [31:0] wd   [2];
   logic        rdy  [2];
   logic        rspv [2];
   logic [31:0] rd   [2];
   logic        er   [2];

   logic [7:0] mdl [2][256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(8), .DEPTH(63), .WAIT_STATES(2)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
      .req_addr(ad[0]), .req_funct3(f3[0]), .req_wdata(wd[0]),
      .rsp_valid(rspv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

   data_mem_responder #(.ADDR_W(8), .DEPTH(64), .WAIT_STATES(0)) dut1 (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
      .req_addr(ad[1]), .req_funct3(f3[1]), .req_wdata(wd[1]),
      .rsp_valid(rspv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

   function automatic int exp_lat(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   // Reference: byte memory, RV32I size/sign rules, legality rules evaluated directly.
   function automatic void model(input int i, input logic w, input logic [7:0] a, input logic [2:0] fn,
                                 input logic [31:0] data, output logic [31:0] res, output logic e);
      int depth = (i == 0) ? 63 : 64;
      int nb = 1 << fn[1:0];
      logic [31:0] v = 0;
      if (w) e = (fn > 3'd2);
      else   e = (fn == 3'd3 || fn == 3'd6 || fn == 3'd7);
      if (fn[1:0] == 2'd1 && (a % 2) != 0) e = 1'b1;
      if (fn[1:0] == 2'd2 && (a % 4) != 0) e = 1'b1;
      if ((int'(a) / 4) >= depth) e = 1'b1;
      res = 32'd0;
      if (!e) begin
         if (w) begin
            for (int b = 0; b < nb; b++) mdl[i][int'(a) + b] = data[8*b +: 8];
         end else begin
            for (int b = 0; b < nb; b++) v[8*b +: 8] = mdl[i][int'(a) + b];
            if (!fn[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!fn[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            res = v;
         end
      end
   endfunction

   task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [2:0] fn,
                         input logic [31:0] data, output logic [31:0] r, output logic e, output int lat);
      int g = 0;
      @(negedge clk);
      we[i] = w; ad[i] = a; f3[i] = fn; wd[i] = data; rv[i] = 1'b1;
      while (rdy[i] !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      r = 32'd0; e = 1'b0; lat = -1;
      if (g >= 50) begin
         checks++; errors++;
         $display("FAIL ready_timeout inst=%0d req_ready never high", i);
         rv[i] = 1'b0;
         return;
      end
      @(negedge clk);
      rv[i] = 1'b0;
      lat = 1;
      while (rspv[i] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      r = rd[i]; e = er[i];
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; we[i] = 1'b0; ad[i] = 8'd0; f3[i] = 3'd0; wd[i] = 32'd0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rdy[i] !== 1'b1 || rspv[i] !== 1'b0 || rd[i] !== 32'd0 || er[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset inst=%0d got rdy=%b rspv=%b rdata=%h err=%b expected 1 0 0 0",
                     i, rdy[i], rspv[i], rd[i], er[i]);
         end
      end
   endtask

   task automatic init_mem;
      logic [31:0] r; logic e; int lat;
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 256; a++) mdl[i][a] = 8'd0;
      for (int i = 0; i < 2; i++)
         for (int wi = 0; wi < ((i == 0) ? 63 : 64); wi++)
            do_req(i, 1'b1, 8'(wi * 4), 3'b010, 32'd0, r, e, lat);
   endtask

   task automatic test_word_rw;
      logic [31:0] r, m; logic e, me; int lat;
      model(0, 1'b1, 8'h10, 3'b010, 32'hDEADBEEF, m, me);
      do_req(0, 1'b1, 8'h10, 3'b010, 32'hDEADBEEF, r, e, lat);
      checks++;
      if (r !== 32'd0 || e !== 1'b0 || lat != 3) begin
         errors++;
         $display("FAIL sw_0x10 got rdata=%h err=%b lat=%0d expected 00000000 0 3", r, e, lat);
      end
      model(0, 1'b0, 8'h10, 3'b010, 32'd0, m, me);
      do_req(0, 1'b0, 8'h10, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'hDEADBEEF || e !== 1'b0 || lat != 3) begin
         errors++;
         $display("FAIL lw_0x10 got rdata=%h err=%b lat=%0d expected deadbeef 0 3", r, e, lat);
      end
   endtask

   task automatic test_byte_half;
      logic [31:0] r, m; logic e, me; int lat;
      model(0, 1'b1, 8'h13, 3'b000, 32'h0000_0080, m, me);
      do_req(0, 1'b1, 8'h13, 3'b000, 32'h0000_0080, r, e, lat);
      do_req(0, 1'b0, 8'h13, 3'b000, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'hFFFF_FF80 || e !== 1'b0) begin
         errors++;
         $display("FAIL lb_0x13 got %h err=%b expected ffffff80 0", r, e);
      end
      do_req(0, 1'b0, 8'h13, 3'b100, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'h0000_0080 || e !== 1'b0) begin
         errors++;
         $display("FAIL lbu_0x13 got %h err=%b expected 00000080 0", r, e);
      end
      do_req(0, 1'b0, 8'h12, 3'b001, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'hFFFF_80AD || e !== 1'b0) begin
         errors++;
         $display("FAIL lh_0x12 got %h err=%b expected ffff80ad 0", r, e);
      end
      do_req(0, 1'b0, 8'h10, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'h80AD_BEEF) begin
         errors++;
         $display("FAIL lanes_intact got %h expected 80adbeef", r);
      end
      do_req(0, 1'b0, 8'h10, 3'b101, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL lhu_0x10 got %h expected 0000beef", r);
      end
   endtask

   task automatic test_errors;
      logic [31:0] r, m; logic e, me; int lat;
      do_req(0, 1'b0, 8'h11, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'd0 || e !== 1'b1 || lat != 3) begin
         errors++;
         $display("FAIL lw_misaligned got rdata=%h err=%b lat=%0d expected 0 1 3", r, e, lat);
      end
      do_req(0, 1'b1, 8'h15, 3'b001, 32'hFFFF_FFFF, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin
         errors++;
         $display("FAIL sh_misaligned got err=%b rdata=%h expected 1 0", e, r);
      end
      model(0, 1'b0, 8'h14, 3'b010, 32'd0, m, me);
      do_req(0, 1'b0, 8'h14, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== m || e !== 1'b0) begin
         errors++;
         $display("FAIL sh_no_write got %h err=%b expected %h 0", r, e, m);
      end
      do_req(0, 1'b0, 8'hFC, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin
         errors++;
         $display("FAIL lw_out_of_range got err=%b rdata=%h expected 1 0", e, r);
      end
      do_req(0, 1'b0, 8'h10, 3'b011, 32'd0, r, e, lat);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin
         errors++;
         $display("FAIL load_f3_011 got err=%b rdata=%h expected 1 0", e, r);
      end
      do_req(0, 1'b1, 8'h18, 3'b100, 32'h1234_5678, r, e, lat);
      checks++;
      if (e !== 1'b1) begin
         errors++;
         $display("FAIL store_f3_100 got err=%b expected 1", e);
      end
      model(0, 1'b0, 8'h18, 3'b010, 32'd0, m, me);
      do_req(0, 1'b0, 8'h18, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== m) begin
         errors++;
         $display("FAIL bad_store_no_write got %h expected %h", r, m);
      end
   endtask

   task automatic test_random;
      logic [31:0] r, m, data; logic e, me, w; logic [7:0] a; logic [2:0] fn; int lat, i;
      for (int n = 0; n < 120; n++) begin
         i    = n % 2;
         w    = 1'($urandom_range(0, 1));
         a    = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & 8'hFC;
         fn   = 3'($urandom_range(0, 7));
         data = $urandom;
         model(i, w, a, fn, data, m, me);
         do_req(i, w, a, fn, data, r, e, lat);
         checks++;
         if (r !== m || e !== me || lat != exp_lat(i)) begin
            errors++;
            $display("FAIL random n=%0d inst=%0d we=%b addr=%h f3=%0d got rdata=%h err=%b lat=%0d expected %h %b %0d",
                     n, i, w, a, fn, r, e, lat, m, me, exp_lat(i));
         end
      end
   endtask

   task automatic test_back_to_back;
      localparam int N = 8;
      logic [31:0] q_d[$];
      logic        q_e[$];
      logic        lw [N];
      logic [7:0]  la [N];
      logic [2:0]  lf [N];
      logic [31:0] ld [N];
      logic [31:0] m; logic me;
      int idx = 0, cyc = 0, last = -1, nrsp = 0;
      bit pend = 0;
      for (int k = 0; k < N; k++) begin
         lw[k] = 1'(k % 2 == 0);
         la[k] = 8'($urandom_range(0, 62) * 4);
         lf[k] = 3'($urandom_range(0, 5));
         ld[k] = $urandom;
      end
      @(negedge clk);
      we[0] = lw[0]; ad[0] = la[0]; f3[0] = lf[0]; wd[0] = ld[0]; rv[0] = 1'b1;
      while ((idx < N || q_d.size() > 0) && cyc < 200) begin
         if (rspv[0] === 1'b1) begin
            nrsp++;
            checks++;
            if (q_d.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_rsp got rsp_valid=1 expected 0");
            end else begin
               m = q_d.pop_front(); me = q_e.pop_front();
               if (rd[0] !== m || er[0] !== me) begin
                  errors++;
                  $display("FAIL b2b_rsp got rdata=%h err=%b expected %h %b", rd[0], er[0], m, me);
               end
            end
         end
         if (idx < N && rdy[0] === 1'b1) begin
            model(0, lw[idx], la[idx], lf[idx], ld[idx], m, me);
            q_d.push_back(m); q_e.push_back(me);
            if (last >= 0) begin
               checks++;
               if (cyc - last != 4) begin
                  errors++;
                  $display("FAIL b2b_ready_spacing got %0d expected 4", cyc - last);
               end
            end
            last = cyc;
            pend = 1;
         end
         @(negedge clk);
         cyc++;
         if (pend) begin
            pend = 0;
            idx++;
            if (idx < N) begin
               we[0] = lw[idx]; ad[0] = la[idx]; f3[0] = lf[idx]; wd[0] = ld[idx];
            end else rv[0] = 1'b0;
         end
      end
      rv[0] = 1'b0;
      checks++;
      if (nrsp != N || cyc >= 200) begin
         errors++;
         $display("FAIL b2b_rsp_count got %0d in %0d cycles expected %0d", nrsp, cyc, N);
      end
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] r, m; logic e, me; int lat, seen = 0;
      model(0, 1'b1, 8'h20, 3'b010, 32'd0, m, me);
      do_req(0, 1'b1, 8'h20, 3'b010, 32'd0, r, e, lat);
      @(negedge clk);
      we[0] = 1'b1; ad[0] = 8'h20; f3[0] = 3'b010; wd[0] = 32'h1234_5678; rv[0] = 1'b1;
      @(negedge clk);
      rv[0] = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (rspv[0] === 1'b1) seen++;
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rspv[0] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || rdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_op got rsp_count=%0d ready=%b expected 0 1", seen, rdy[0]);
      end
      model(0, 1'b0, 8'h20, 3'b010, 32'd0, m, me);
      do_req(0, 1'b0, 8'h20, 3'b010, 32'd0, r, e, lat);
      checks++;
      if (r !== 32'd0 || r !== m || e !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_write got %h err=%b expected 00000000 0", r, e);
      end
   endtask

   task automatic test_zero_wait;
      logic [31:0] r, m; logic e, me; int lat;
      model(1, 1'b1, 8'h40, 3'b010, 32'hCAFE_F00D, m, me);
      do_req(1, 1'b1, 8'h40, 3'b010, 32'hCAFE_F00D, r, e, lat);
      @(negedge clk);
      we[1] = 1'b0; ad[1] = 8'h40; f3[1] = 3'b010; rv[1] = 1'b1;
      @(negedge clk);
      rv[1] = 1'b0;
      checks++;
      if (rspv[1] !== 1'b1 || rdy[1] !== 1'b0 || rd[1] !== 32'hCAFE_F00D || er[1] !== 1'b0) begin
         errors++;
         $display("FAIL ws0_resp got rspv=%b rdy=%b rdata=%h err=%b expected 1 0 cafef00d 0",
                  rspv[1], rdy[1], rd[1], er[1]);
      end
      @(negedge clk);
      checks++;
      if (rspv[1] !== 1'b0 || rdy[1] !== 1'b1 || rd[1] !== 32'd0) begin
         errors++;
         $display("FAIL ws0_after got rspv=%b rdy=%b rdata=%h expected 0 1 00000000", rspv[1], rdy[1], rd[1]);
      end
   endtask

   initial begin
      test_reset();
      init_mem();
      test_word_rw();
      test_byte_half();
      test_errors();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      test_zero_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
